// File: rtl/aes_inv_mix_columns_iter.sv
// Iterative AES InvMixColumns engine: transforms ColsPerCycle columns of a 128-bit state per clock.
// Optional forward-MixColumns self-check when AES_INVMIX_SELFCHECK_EN is defined.
module aes_inv_mix_columns_iter #(
    parameter int ColsPerCycle = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [3:0][3:0][7:0] state_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [3:0][3:0][7:0] state_o,
    output logic                 err_o
);
    localparam int NumCycles = 4 / ColsPerCycle;

    if (ColsPerCycle != 1 && ColsPerCycle != 2 && ColsPerCycle != 4) begin : g_bad_cfg
        $error("aes_inv_mix_columns_iter: ColsPerCycle must be 1, 2 or 4");
    end

    function automatic logic [7:0] aes_mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] aes_mul4(input logic [7:0] b);
        return aes_mul2(aes_mul2(b));
    endfunction

    // Forward MixColumns on one column, index = row.
    function automatic logic [3:0][7:0] mix_col(input logic [3:0][7:0] a);
        logic [3:0][7:0] o;
        o[0] = aes_mul2(a[0]) ^ aes_mul2(a[1]) ^ a[1] ^ a[2] ^ a[3];
        o[1] = aes_mul2(a[1]) ^ aes_mul2(a[2]) ^ a[2] ^ a[3] ^ a[0];
        o[2] = aes_mul2(a[2]) ^ aes_mul2(a[3]) ^ a[3] ^ a[0] ^ a[1];
        o[3] = aes_mul2(a[3]) ^ aes_mul2(a[0]) ^ a[0] ^ a[1] ^ a[2];
        return o;
    endfunction

    // Inverse MixColumns via Satoh: fold the 04 terms in, then reuse forward MixColumns.
    function automatic logic [3:0][7:0] inv_mix_col(input logic [3:0][7:0] a);
        logic [7:0]      u;
        logic [7:0]      v;
        logic [3:0][7:0] p;
        u    = aes_mul4(a[0] ^ a[2]);
        v    = aes_mul4(a[1] ^ a[3]);
        p[0] = a[0] ^ u;
        p[1] = a[1] ^ v;
        p[2] = a[2] ^ u;
        p[3] = a[3] ^ v;
        return mix_col(p);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e                 fsm_reg, fsm_next;
    logic [1:0]           cnt_reg, cnt_next;
    logic [3:0][3:0][7:0] buf_reg, buf_next;
    logic                 valid_reg, valid_next;

    logic [ColsPerCycle-1:0][1:0]      lane_col;
    logic [ColsPerCycle-1:0][3:0][7:0] lane_in;
    logic [ColsPerCycle-1:0][3:0][7:0] lane_out;

    for (genvar gi = 0; gi < ColsPerCycle; gi++) begin : g_lane
        assign lane_col[gi] = 2'((int'(cnt_reg) * ColsPerCycle + gi) % 4);
        for (genvar gr = 0; gr < 4; gr++) begin : g_row
            assign lane_in[gi][gr] = buf_reg[gr][lane_col[gi]];
        end
        assign lane_out[gi] = inv_mix_col(lane_in[gi]);
    end

    always_comb begin
        fsm_next   = fsm_reg;
        cnt_next   = cnt_reg;
        buf_next   = buf_reg;
        valid_next = valid_reg;
        if (clear_i) begin
            fsm_next   = IDLE;
            cnt_next   = '0;
            buf_next   = '0;
            valid_next = 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (in_valid_i) begin
                        buf_next = state_i;
                        cnt_next = '0;
                        fsm_next = BUSY;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < ColsPerCycle; l++) begin
                        for (int r = 0; r < 4; r++) begin
                            buf_next[r][lane_col[l]] = lane_out[l][r];
                        end
                    end
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'(NumCycles - 1)) begin
                        fsm_next = DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle registers the valid flag; the result is presented from the next one.
                    if (!valid_reg) begin
                        valid_next = 1'b1;
                    end else if (out_ready_i) begin
                        valid_next = 1'b0;
                        cnt_next   = '0;
                        fsm_next   = IDLE;
                    end
                end
                default: begin
                    fsm_next   = IDLE;
                    cnt_next   = '0;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_reg   <= IDLE;
            cnt_reg   <= '0;
            buf_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            fsm_reg   <= fsm_next;
            cnt_reg   <= cnt_next;
            buf_reg   <= buf_next;
            valid_reg <= valid_next;
        end
    end

    assign in_ready_o  = (fsm_reg == IDLE);
    assign out_valid_o = valid_reg;
    assign state_o     = valid_reg ? buf_reg : '0;

`ifdef AES_INVMIX_SELFCHECK_EN
    logic [3:0][3:0][7:0] shadow_reg;
    logic [3:0][3:0][7:0] fwd;
    logic [3:0][3:0][7:0] col_o;
    logic [3:0][3:0][7:0] fwd_col;
    logic                 err_reg;
    logic                 mismatch;

    for (genvar gi = 0; gi < 4; gi++) begin : g_chk
        for (genvar gr = 0; gr < 4; gr++) begin : g_row
            assign col_o[gi][gr] = state_o[gr][gi];
            assign fwd[gr][gi]   = fwd_col[gi][gr];
        end
        assign fwd_col[gi] = mix_col(col_o[gi]);
    end

    assign mismatch = valid_reg && (fwd != shadow_reg);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (!clear_i && fsm_reg == IDLE && in_valid_i) begin
                shadow_reg <= state_i;
            end
            // Sticky: only rst_ni clears it, clear_i deliberately does not.
            err_reg <= err_reg | mismatch;
        end
    end

    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_inv_mix_columns_iter.sv
// Self-checking bench for aes_inv_mix_columns_iter: three instances (1, 2 and 4 columns per cycle)
// with a scoreboard queue of reference InvMixColumns results.
module tb_aes_inv_mix_columns_iter;
    typedef logic [3:0][3:0][7:0] state_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    logic   clear = 1'b0;
    logic   in_valid  [3];
    logic   in_ready  [3];
    state_t state_in  [3];
    logic   out_valid [3];
    logic   out_ready [3];
    state_t state_out [3];
    logic   err       [3];

    int     errors = 0;
    int     checks = 0;
    state_t sb[$];

    always #5 clk = ~clk;

    aes_inv_mix_columns_iter #(.ColsPerCycle(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .state_i(state_in[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .state_o(state_out[0]),
        .err_o(err[0])
    );
    aes_inv_mix_columns_iter #(.ColsPerCycle(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .state_i(state_in[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .state_o(state_out[1]),
        .err_o(err[1])
    );
    aes_inv_mix_columns_iter #(.ColsPerCycle(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]), .state_i(state_in[2]),
        .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .state_o(state_out[2]),
        .err_o(err[2])
    );

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic state_t model(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[r][c] = gmul(8'h0e, s[r][c]) ^ gmul(8'h0b, s[(r+1)%4][c]) ^
                          gmul(8'h0d, s[(r+2)%4][c]) ^ gmul(8'h09, s[(r+3)%4][c]);
            end
        end
        return o;
    endfunction

    function automatic state_t from_cols(input logic [31:0] c0, input logic [31:0] c1,
                                         input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0] w[4];
        state_t      s;
        w[0] = c0; w[1] = c1; w[2] = c2; w[3] = c3;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[r][c] = w[c][(31 - 8*r) -: 8];
            end
        end
        return s;
    endfunction

    function automatic state_t rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one state; inputs change 1 time unit after an edge, accept happens on the next edge.
    task automatic send(input int d, input state_t s, input bit push, input string name);
        checks++;
        if (in_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b required 1", name, in_ready[d]);
        end
        in_valid[d] = 1'b1;
        state_in[d] = s;
        if (push) sb.push_back(model(s));
        tick();
        in_valid[d] = 1'b0;
        state_in[d] = rand_state();
    endtask

    task automatic await_out(input int d, input int exp_lat, input string name);
        int     lat;
        state_t exp;
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (out_valid[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: out_valid=%b required 1 within 20 cycles", name, out_valid[d]);
            return;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: output with no expected entry", name);
        end else begin
            exp = sb.pop_front();
            if (state_out[d] !== exp) begin
                errors++;
                $display("FAIL %s data: got %h required %h", name, state_out[d], exp);
            end
        end
        $display("txn %s dut=%0d lat=%0d state_o=%h", name, d, lat, state_out[d]);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({in_ready[d], out_valid[d], err[d]} !== 3'b100 || state_out[d] !== '0) begin
                errors++;
                $display("FAIL reset dut%0d: rdy/vld/err=%b%b%b state_o=%h required 100 and 0",
                         d, in_ready[d], out_valid[d], err[d], state_out[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fips();
        state_t exp;
        exp = from_cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5);
        out_ready[0] = 1'b1;
        send(0, from_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6), 1'b0, "fips");
        sb.push_back(exp);
        await_out(0, 5, "fips");
        tick();
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL fips after-handshake: out_valid=%b in_ready=%b required 0 1",
                     out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_backpressure();
        state_t exp;
        exp = from_cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5);
        out_ready[0] = 1'b0;
        send(0, from_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6), 1'b1, "bp");
        await_out(0, 5, "bp");
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || state_out[0] !== exp) begin
                errors++;
                $display("FAIL bp hold cycle %0d: vld=%b rdy=%b state_o=%h required 1 0 %h",
                         i, out_valid[0], in_ready[0], state_out[0], exp);
            end
        end
        out_ready[0] = 1'b1;
        tick();
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp release: out_valid=%b in_ready=%b required 0 1", out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_back_to_back();
        out_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(0, rand_state(), 1'b1, "b2b");
            await_out(0, 5, "b2b");
            tick();
        end
    endtask

    task automatic test_variants();
        state_t s;
        s = from_cols(32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6);
        out_ready[1] = 1'b1;
        out_ready[2] = 1'b1;
        send(2, s, 1'b1, "cols4");
        await_out(2, 2, "cols4");
        tick();
        send(1, s, 1'b1, "cols2");
        await_out(1, 3, "cols2");
        tick();
        for (int i = 0; i < 3; i++) begin
            send(1, rand_state(), 1'b1, "cols2_rand");
            await_out(1, 3, "cols2_rand");
            tick();
            send(2, rand_state(), 1'b1, "cols4_rand");
            await_out(2, 2, "cols4_rand");
            tick();
        end
    endtask

    task automatic test_clear();
        bit saw_valid;
        out_ready[0] = 1'b1;
        // Clear while IDLE with a competing input: input must be ignored.
        clear       = 1'b1;
        in_valid[0] = 1'b1;
        state_in[0] = rand_state();
        #1;
        checks++;
        if (in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL clear idle ready: in_ready=%b required 1", in_ready[0]);
        end
        tick();
        clear       = 1'b0;
        in_valid[0] = 1'b0;
        checks++;
        if (in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL clear idle ignore: in_ready=%b required 1", in_ready[0]);
        end
        // Clear during the second BUSY cycle.
        send(0, from_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6), 1'b0, "clr");
        tick();
        clear       = 1'b1;
        in_valid[0] = 1'b1;
        state_in[0] = rand_state();
        tick();
        clear       = 1'b0;
        in_valid[0] = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || state_out[0] !== '0) begin
            errors++;
            $display("FAIL clear busy: vld=%b rdy=%b state_o=%h required 0 1 0",
                     out_valid[0], in_ready[0], state_out[0]);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid[0] === 1'b1) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL clear no-output: out_valid seen=1 required 0");
        end
        send(0, from_cols(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc), 1'b0, "clr_next");
        sb.push_back(from_cols(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345));
        await_out(0, 5, "clr_next");
        tick();
    endtask

    task automatic test_async_reset();
        bit saw_valid;
        // Mid-BUSY.
        out_ready[0] = 1'b1;
        send(0, rand_state(), 1'b0, "arst_busy");
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || state_out[0] !== '0) begin
            errors++;
            $display("FAIL arst busy: vld=%b rdy=%b state_o=%h required 0 1 0",
                     out_valid[0], in_ready[0], state_out[0]);
        end
        #3 rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid[0] === 1'b1) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL arst partial: out_valid seen=1 required 0");
        end
        // Mid-DONE while the consumer stalls.
        out_ready[0] = 1'b0;
        send(0, rand_state(), 1'b1, "arst_done");
        await_out(0, 5, "arst_done");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || state_out[0] !== '0) begin
            errors++;
            $display("FAIL arst done: vld=%b rdy=%b state_o=%h required 0 1 0",
                     out_valid[0], in_ready[0], state_out[0]);
        end
        #3 rst_n = 1'b1;
        out_ready[0] = 1'b1;
        tick();
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            state_in[d]  = '0;
            out_ready[d] = 1'b0;
        end
        test_reset();
        test_fips();
        test_backpressure();
        test_back_to_back();
        test_variants();
        test_clear();
        test_async_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (err[d] !== 1'b0) begin
                errors++;
                $display("FAIL err_o dut%0d: got %b required 0", d, err[d]);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
